// File: rtl/array_adapt_pkg.sv
// Shared constants and types for the array port adapter.
// The optional round-robin arbiter is selected by defining ARRAY_ADAPT_RR_ARB_EN.
package array_adapt_pkg;

    localparam int DEF_ADDR_W     = 2;
    localparam int DEF_DATA_W     = 34;
    localparam int DEF_MASK_W     = 2;
    localparam int DEF_RESP_DEPTH = 2;
    localparam int LANE_W         = DEF_DATA_W / DEF_MASK_W;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } grant_e;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/array_rsp_fifo.sv
// Small synchronous FIFO that holds read responses until the consumer takes them.
module array_rsp_fifo
    import array_adapt_pkg::*;
#(
    parameter int DEPTH = DEF_RESP_DEPTH,
    parameter int WIDTH = DEF_DATA_W,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full queue may still accept a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = storage[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/array_port_adapter.sv
// Merges write and read request channels onto one single-port masked array and queues read data.
// Define ARRAY_ADAPT_RR_ARB_EN for round-robin arbitration; otherwise writes have fixed priority.
module array_port_adapter
    import array_adapt_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MASK_W     = DEF_MASK_W,
    parameter int RESP_DEPTH = DEF_RESP_DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [MASK_W-1:0] wr_mask,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = cnt_width(RESP_DEPTH);

    grant_e           grant;
    logic             inflight;
    logic [CNT_W-1:0] occ;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [CNT_W:0]   pending;
    logic             rd_credit;
    logic             rd_elig;

    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = inflight || !fifo_empty;

    // Every read must have a guaranteed queue slot by the time its data returns.
    assign pending   = {1'b0, occ} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    assign rd_credit = (pending < (CNT_W + 1)'(RESP_DEPTH)) && !(fifo_full && !pop);
    assign rd_elig   = rd_valid && rd_credit;

`ifdef ARRAY_ADAPT_RR_ARB_EN
    logic prio_rd;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_rd <= 1'b0;
        end else if (grant == GNT_WR) begin
            prio_rd <= 1'b1;
        end else if (grant == GNT_RD) begin
            prio_rd <= 1'b0;
        end
    end

    always_comb begin
        grant = GNT_NONE;
        if (wr_valid && rd_elig) begin
            grant = prio_rd ? GNT_RD : GNT_WR;
        end else if (wr_valid) begin
            grant = GNT_WR;
        end else if (rd_elig) begin
            grant = GNT_RD;
        end
    end
`else
    always_comb begin
        grant = GNT_NONE;
        if (wr_valid) begin
            grant = GNT_WR;
        end else if (rd_elig) begin
            grant = GNT_RD;
        end
    end
`endif

    always_comb begin
        wr_ready  = 1'b0;
        rd_ready  = 1'b0;
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        case (grant)
            GNT_WR: begin
                wr_ready  = 1'b1;
                mem_en    = 1'b1;
                mem_wmode = 1'b1;
                mem_addr  = wr_addr;
                mem_wmask = wr_mask;
                mem_wdata = wr_data;
            end
            GNT_RD: begin
                rd_ready  = 1'b1;
                mem_en    = 1'b1;
                mem_addr  = rd_addr;
            end
            default: begin
            end
        endcase
    end

    // The array returns read data one cycle after issue; capture it that cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= (grant == GNT_RD);
        end
    end

    array_rsp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (mem_rdata),
        .pop       (pop),
        .pop_data  (rsp_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occ)
    );

endmodule

// File: tb/tb_array_port_adapter.sv
// Directed bench for array_port_adapter with a behavioural model of the masked array macro.
module tb_array_port_adapter;
    import array_adapt_pkg::*;

    localparam logic [33:0] D1  = 34'h2_AAAA_5555;
    localparam logic [33:0] D2F = 34'h3_FFFF_FFFF;
    localparam logic [33:0] D2  = 34'h3_FFFE_0000;
    localparam logic [33:0] D0  = 34'h0_1234_5678;
    localparam logic [33:0] D3  = 34'h1_0F0F_0F0F;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_addr = '0;
    logic [1:0]  wr_mask = '0;
    logic [33:0] wr_data = '0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [1:0]  rd_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [33:0] rsp_data;
    logic        mem_en;
    logic        mem_wmode;
    logic [1:0]  mem_addr;
    logic [1:0]  mem_wmask;
    logic [33:0] mem_wdata;
    logic [33:0] mem_rdata = '0;
    logic        busy;

    logic [33:0] arr [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wv;
        logic [1:0]  wa;
        logic [1:0]  wm;
        logic [33:0] wd;
        logic        rv;
        logic [1:0]  ra;
        logic        rr;
        logic        ewr;
        logic        erd;
        logic        ersp;
        logic [33:0] edata;
        logic        ebusy;
    } vec_t;

    vec_t vecs[$];

    array_port_adapter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_mask   (wr_mask),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .mem_en    (mem_en),
        .mem_wmode (mem_wmode),
        .mem_addr  (mem_addr),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Array macro model: masked write, registered read data.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_wmode) begin
                for (int l = 0; l < DEF_MASK_W; l++) begin
                    if (mem_wmask[l]) begin
                        arr[mem_addr][l*LANE_W +: LANE_W] <= mem_wdata[l*LANE_W +: LANE_W];
                    end
                end
            end else begin
                mem_rdata <= arr[mem_addr];
            end
        end
    end

    function automatic void add_vec(input logic wv, input logic [1:0] wa, input logic [1:0] wm,
                                    input logic [33:0] wd, input logic rv, input logic [1:0] ra,
                                    input logic rr, input logic ewr, input logic erd,
                                    input logic ersp, input logic [33:0] edata, input logic ebusy);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wm = wm; v.wd = wd; v.rv = rv; v.ra = ra; v.rr = rr;
        v.ewr = ewr; v.erd = erd; v.ersp = ersp; v.edata = edata; v.ebusy = ebusy;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name, input int idx, input logic [33:0] act,
                                input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (vec %0d): got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clock);
        wr_valid  = v.wv;
        wr_addr   = v.wa;
        wr_mask   = v.wm;
        wr_data   = v.wd;
        rd_valid  = v.rv;
        rd_addr   = v.ra;
        rsp_ready = v.rr;
        #1;
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        check_output("wr_ready", idx, 34'(wr_ready), 34'(v.ewr));
        check_output("rd_ready", idx, 34'(rd_ready), 34'(v.erd));
        check_output("rsp_valid", idx, 34'(rsp_valid), 34'(v.ersp));
        check_output("busy", idx, 34'(busy), 34'(v.ebusy));
        check_output("mem_en", idx, 34'(mem_en), 34'(v.ewr | v.erd));
        if (v.ersp) check_output("rsp_data", idx, rsp_data, v.edata);
        if (v.ewr | v.erd) begin
            check_output("mem_wmode", idx, 34'(mem_wmode), 34'(v.ewr));
            check_output("mem_addr", idx, 34'(mem_addr), v.ewr ? 34'(v.wa) : 34'(v.ra));
        end
        if (v.ewr) begin
            check_output("mem_wmask", idx, 34'(mem_wmask), 34'(v.wm));
            check_output("mem_wdata", idx, mem_wdata, v.wd);
        end
    endtask

    initial begin
        vec_t idle;
        // Idle after reset
        add_vec(0,0,0,0,    0,0,1, 0,0, 0,0,  0);
        // Full-mask write then read of the same word, data two cycles after accept
        add_vec(1,1,3,D1,   0,0,1, 1,0, 0,0,  0);
        add_vec(0,0,0,0,    1,1,1, 0,1, 0,0,  0);
        add_vec(0,0,0,0,    0,0,1, 0,0, 0,0,  1);
        add_vec(0,0,0,0,    0,0,1, 0,0, 1,D1, 1);
        add_vec(0,0,0,0,    0,0,1, 0,0, 0,0,  0);
        // Partial-mask overwrite of the low lane
        add_vec(1,2,3,D2F,  0,0,1, 1,0, 0,0,  0);
        add_vec(1,2,1,0,    0,0,1, 1,0, 0,0,  0);
        add_vec(0,0,0,0,    1,2,1, 0,1, 0,0,  0);
        add_vec(0,0,0,0,    0,0,1, 0,0, 0,0,  1);
        add_vec(0,0,0,0,    0,0,1, 0,0, 1,D2, 1);
        // Back-to-back reads of all four words
        add_vec(1,0,3,D0,   0,0,1, 1,0, 0,0,  0);
        add_vec(1,3,3,D3,   0,0,1, 1,0, 0,0,  0);
        add_vec(0,0,0,0,    1,0,1, 0,1, 0,0,  0);
        add_vec(0,0,0,0,    1,1,1, 0,1, 0,0,  1);
        add_vec(0,0,0,0,    1,2,1, 0,1, 1,D0, 1);
        add_vec(0,0,0,0,    1,3,1, 0,1, 1,D1, 1);
        add_vec(0,0,0,0,    0,0,1, 0,0, 1,D2, 1);
        add_vec(0,0,0,0,    0,0,1, 0,0, 1,D3, 1);
        add_vec(0,0,0,0,    0,0,1, 0,0, 0,0,  0);
        // Backpressure: queue fills, third read blocked, write still proceeds
        add_vec(0,0,0,0,    1,1,0, 0,1, 0,0,  0);
        add_vec(0,0,0,0,    1,2,0, 0,1, 0,0,  1);
        add_vec(0,0,0,0,    1,3,0, 0,0, 1,D1, 1);
        add_vec(0,0,0,0,    1,3,0, 0,0, 1,D1, 1);
        add_vec(1,0,0,D2F,  1,3,0, 1,0, 1,D1, 1);
        add_vec(0,0,0,0,    1,3,1, 0,1, 1,D1, 1);
        add_vec(0,0,0,0,    0,0,1, 0,0, 1,D2, 1);
        add_vec(0,0,0,0,    0,0,1, 0,0, 1,D3, 1);
        add_vec(0,0,0,0,    0,0,1, 0,0, 0,0,  0);
        // Simultaneous write and read requests for four cycles
`ifdef ARRAY_ADAPT_RR_ARB_EN
        add_vec(1,0,0,0,    1,2,1, 1,0, 0,0,  0);
        add_vec(1,0,0,0,    1,2,1, 0,1, 0,0,  0);
        add_vec(1,0,0,0,    1,2,1, 1,0, 0,0,  1);
        add_vec(1,0,0,0,    1,2,1, 0,1, 1,D2, 1);
        add_vec(0,0,0,0,    0,0,1, 0,0, 0,0,  1);
        add_vec(0,0,0,0,    0,0,1, 0,0, 1,D2, 1);
        add_vec(0,0,0,0,    0,0,1, 0,0, 0,0,  0);
`else
        add_vec(1,0,0,0,    1,2,1, 1,0, 0,0,  0);
        add_vec(1,0,0,0,    1,2,1, 1,0, 0,0,  0);
        add_vec(1,0,0,0,    1,2,1, 1,0, 0,0,  0);
        add_vec(1,0,0,0,    1,2,1, 1,0, 0,0,  0);
        add_vec(0,0,0,0,    0,0,1, 0,0, 0,0,  0);
        add_vec(0,0,0,0,    0,0,1, 0,0, 0,0,  0);
        add_vec(0,0,0,0,    0,0,1, 0,0, 0,0,  0);
`endif

        repeat (2) @(negedge clock);
        #1;
        check_output("reset_rsp_valid", -1, 34'(rsp_valid), 34'd0);
        check_output("reset_busy", -1, 34'(busy), 34'd0);
        check_output("reset_mem_en", -1, 34'(mem_en), 34'd0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_vec(vecs[i], i);
        end

        // Reset asserted while a read is in flight: the response must vanish
        idle = vecs[0];
        apply_stimulus(vecs[2]);
        check_output("rst_rd_ready", 100, 34'(rd_ready), 34'd1);
        apply_stimulus(idle);
        check_output("rst_inflight_busy", 101, 34'(busy), 34'd1);
        reset_n = 1'b0;
        #1;
        check_output("rst_busy_low", 102, 34'(busy), 34'd0);
        check_output("rst_rsp_low", 102, 34'(rsp_valid), 34'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(idle);
            check_output("post_rst_rsp_valid", 103 + k, 34'(rsp_valid), 34'd0);
            check_output("post_rst_busy", 103 + k, 34'(busy), 34'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
